// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: fetch FSM states and the NOP encoding.
// HOLD is only ever entered when FETCH_BUFFER_EN is defined.
package pipeline_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

endpackage

// File: rtl/pipeline_fetch_unit_stage_pkg.sv
// Fetch-stage header: the registered result handed from fetch to decode.
package fetch_stage_pkg;

  typedef struct packed {
    logic [31:0] programCounter;
    logic        programCounterChangedTimes;
    logic [31:0] instruction;
    logic        bubbled;
  } pipeline_result_fetch_t;

endpackage

// File: rtl/pipeline_fetch_unit_skid_buffer.sv
// One-entry skid buffer holding a fetch result that arrived while decode stalled.
// Only built when FETCH_BUFFER_EN is defined.
`ifdef FETCH_BUFFER_EN
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  pipeline_result_fetch_t pushData,
  input  logic                   pop,
  output logic                   entryValid,
  output pipeline_result_fetch_t entryData
);

  logic                   validReg;
  pipeline_result_fetch_t dataReg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      validReg <= 1'b0;
      dataReg  <= '0;
    end else if (push) begin
      validReg <= 1'b1;
      dataReg  <= pushData;
    end else if (pop) begin
      validReg <= 1'b0;
    end
  end

  assign entryValid = validReg;
  assign entryData  = dataReg;

endmodule
`endif

// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch unit: one outstanding request, delay-slot redirects, registered result.
// Define FETCH_BUFFER_EN to add a one-entry skid buffer instead of back-pressuring memory.
module pipeline_fetch_unit
  import pipeline_fetch_unit_pkg::*;
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stallOnDecode,
  input  logic                   jumpEnabled,
  input  logic [31:0]            jumpValue,
  output logic                   imemReqValid,
  input  logic                   imemReqReady,
  output logic [31:0]            imemReqAddr,
  input  logic                   imemRespValid,
  output logic                   imemRespReady,
  input  logic [31:0]            imemRespData,
  output pipeline_result_fetch_t pipelineResultFetch
);

  fetch_state_t           stateReg, stateNext;
  logic [31:0]            fetchPcReg;
  logic [31:0]            pendingTargetReg;
  logic                   pendingJumpReg;
  logic                   changedTimesReg;
  logic [31:0]            inFlightPcReg;
  logic                   inFlightTagReg;
  pipeline_result_fetch_t resultReg;

  logic                   reqFire, respFire, redirect;
  logic                   bufValid;
  pipeline_result_fetch_t bufData;
  pipeline_result_fetch_t respEntry;

  assign reqFire  = imemReqValid && imemReqReady;
  assign respFire = imemRespValid && imemRespReady;
  assign redirect = jumpEnabled && !stallOnDecode;

  assign respEntry = '{programCounter:             inFlightPcReg,
                       programCounterChangedTimes: inFlightTagReg,
                       instruction:                imemRespData,
                       bubbled:                    1'b0};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext     = stateReg;
    imemReqValid  = 1'b0;
    imemRespReady = 1'b0;
    case (stateReg)
      IDLE: stateNext = ISSUE;
      ISSUE: begin
        imemReqValid = 1'b1;
        if (imemReqReady) stateNext = WAIT;
      end
      WAIT: begin
`ifdef FETCH_BUFFER_EN
        imemRespReady = 1'b1;
        if (imemRespValid) stateNext = stallOnDecode ? HOLD : ISSUE;
`else
        imemRespReady = !stallOnDecode;
        if (imemRespValid && !stallOnDecode) stateNext = ISSUE;
`endif
      end
`ifdef FETCH_BUFFER_EN
      HOLD: if (!stallOnDecode) stateNext = ISSUE;
`endif
      default: stateNext = IDLE;
    endcase
  end

  assign imemReqAddr = fetchPcReg;

  // A request presented but not yet accepted is the delay slot, so its redirect waits in pendingJump.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetchPcReg       <= RESET_PC;
      pendingJumpReg   <= 1'b0;
      pendingTargetReg <= 32'h0;
      changedTimesReg  <= 1'b0;
      inFlightPcReg    <= RESET_PC;
      inFlightTagReg   <= 1'b0;
    end else if (reqFire) begin
      inFlightPcReg  <= fetchPcReg;
      inFlightTagReg <= changedTimesReg;
      if (redirect) begin
        fetchPcReg      <= jumpValue;
        changedTimesReg <= ~changedTimesReg;
        pendingJumpReg  <= 1'b0;
      end else if (pendingJumpReg) begin
        fetchPcReg      <= pendingTargetReg;
        changedTimesReg <= ~changedTimesReg;
        pendingJumpReg  <= 1'b0;
      end else begin
        fetchPcReg <= fetchPcReg + 32'd4;
      end
    end else if (redirect) begin
      if (imemReqValid) begin
        pendingJumpReg   <= 1'b1;
        pendingTargetReg <= jumpValue;
      end else begin
        fetchPcReg      <= jumpValue;
        changedTimesReg <= ~changedTimesReg;
        pendingJumpReg  <= 1'b0;
      end
    end
  end

`ifdef FETCH_BUFFER_EN
  logic bufPush, bufPop;
  assign bufPush = respFire && stallOnDecode;
  assign bufPop  = (stateReg == HOLD) && !stallOnDecode;

  fetch_skid_buffer skidBuffer (
    .clock      (clock),
    .reset      (reset),
    .push       (bufPush),
    .pushData   (respEntry),
    .pop        (bufPop),
    .entryValid (bufValid),
    .entryData  (bufData)
  );
`else
  assign bufValid = 1'b0;
  assign bufData  = '0;
`endif

  // Bubbles keep the last PC and tag; only the instruction and bubbled flag change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resultReg <= '{programCounter:             RESET_PC - 32'd4,
                     programCounterChangedTimes: 1'b0,
                     instruction:                NOP_INSTRUCTION,
                     bubbled:                    1'b1};
    end else if (!stallOnDecode) begin
      if (respFire) begin
        resultReg <= respEntry;
      end else if (bufValid) begin
        resultReg <= bufData;
      end else begin
        resultReg.instruction <= NOP_INSTRUCTION;
        resultReg.bubbled     <= 1'b1;
      end
    end
  end

  assign pipelineResultFetch = resultReg;

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Scoreboard bench for pipeline_fetch_unit with a single-outstanding memory model.
// Honours FETCH_BUFFER_EN for the stall-handling checks.
`timescale 1ns/1ps
module tb_pipeline_fetch_unit;
  import pipeline_fetch_unit_pkg::*;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam pipeline_result_fetch_t RESET_RESULT = '{programCounter: RESET_PC - 32'd4,
                                                      programCounterChangedTimes: 1'b0,
                                                      instruction: 32'h0,
                                                      bubbled: 1'b1};

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   stallOnDecode, jumpEnabled;
  logic [31:0]            jumpValue;
  logic                   imemReqValid, imemReqReady;
  logic [31:0]            imemReqAddr;
  logic                   imemRespValid, imemRespReady;
  logic [31:0]            imemRespData;
  pipeline_result_fetch_t pipelineResultFetch;

  pipeline_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clock               (clock),
    .reset               (reset),
    .stallOnDecode       (stallOnDecode),
    .jumpEnabled         (jumpEnabled),
    .jumpValue           (jumpValue),
    .imemReqValid        (imemReqValid),
    .imemReqReady        (imemReqReady),
    .imemReqAddr         (imemReqAddr),
    .imemRespValid       (imemRespValid),
    .imemRespReady       (imemRespReady),
    .imemRespData        (imemRespData),
    .pipelineResultFetch (pipelineResultFetch)
  );

  always #5 clock = ~clock;

  int vectorCount = 0;
  int miscompareCount = 0;

  // scenario knobs
  logic        stallCfg, readyCfg;
  int          latencyMax;
  logic        armValid, armAny, armWait, armFired;
  logic [31:0] armAddr, armTarget;
  // memory model
  logic        memBusy;
  logic [31:0] memAddr;
  int          memWait;
  // reference model
  pipeline_result_fetch_t sb[$];
  pipeline_result_fetch_t expOut, bufEntry;
  logic        bufValid, pendValid, nextIsTarget, modelTag;
  logic [31:0] expAddr, pendTarget;
  logic        sawZero, firstSeen;
  logic [31:0] firstAddr;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic checkValue(input string tag, input logic [65:0] actual, input logic [65:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("FAIL %s: observed %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    memBusy = 1'b0; memAddr = 32'h0; memWait = 0;
    bufValid = 1'b0; bufEntry = '0; expOut = RESET_RESULT;
    expAddr = RESET_PC; pendValid = 1'b0; pendTarget = 32'h0;
    nextIsTarget = 1'b0; modelTag = 1'b0;
    armValid = 1'b0; armAny = 1'b0; armWait = 1'b0; armFired = 1'b0;
    armAddr = 32'h0; armTarget = 32'h0;
    firstSeen = 1'b0; firstAddr = 32'h0;
    stallCfg = 1'b0; readyCfg = 1'b1; latencyMax = 0;
    stallOnDecode = 1'b0; jumpEnabled = 1'b0; jumpValue = 32'h0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = 32'h0;
  endtask

  task automatic checkResetState();
    checkValue("resetResult", pipelineResultFetch, RESET_RESULT);
    checkValue("resetReqValid", {65'b0, imemReqValid}, 66'b0);
    checkValue("resetRespReady", {65'b0, imemRespReady}, 66'b0);
  endtask

  task automatic arm(input logic any, input logic inWait, input logic [31:0] addr, input logic [31:0] target);
    armValid = 1'b1; armAny = any; armWait = inWait; armAddr = addr; armTarget = target; armFired = 1'b0;
  endtask

  task automatic cycle();
    logic reqFire, respFire, redirect;
    pipeline_result_fetch_t entry;
    @(negedge clock);
    if (expOut.bubbled)
      checkValue("bubble", {33'b0, pipelineResultFetch.instruction, pipelineResultFetch.bubbled},
                 {33'b0, NOP_INSTRUCTION, 1'b1});
    else
      checkValue("result", pipelineResultFetch, expOut);
    stallOnDecode = stallCfg;
    imemReqReady  = readyCfg && !memBusy;
    imemRespValid = memBusy && (memWait == 0);
    imemRespData  = memData(memAddr);
    jumpEnabled   = 1'b0;
    jumpValue     = 32'h0;
    if (armValid && !stallCfg &&
        ((!armWait && imemReqValid && (armAny || imemReqAddr == armAddr)) ||
         (armWait && memBusy && !imemReqValid))) begin
      jumpEnabled = 1'b1; jumpValue = armTarget; armValid = 1'b0; armFired = 1'b1;
    end
    #1;
    reqFire  = imemReqValid && imemReqReady;
    respFire = imemRespValid && imemRespReady;
    redirect = jumpEnabled && !stallOnDecode;
`ifdef FETCH_BUFFER_EN
    if (bufValid) checkValue("noReqInHold", {65'b0, imemReqValid}, 66'b0);
`else
    if (stallOnDecode) checkValue("readyUnderStall", {65'b0, imemRespReady}, 66'b0);
`endif
    if (respFire) begin
      checkValue("sbNotEmpty", {65'b0, sb.size() != 0}, {65'b0, 1'b1});
      entry = (sb.size() != 0) ? sb.pop_front() : '0;
      if (!stallOnDecode) begin
        expOut = entry;
        $display("deliver pc=%08h tag=%0d instr=%08h", entry.programCounter,
                 entry.programCounterChangedTimes, entry.instruction);
      end else begin
        bufValid = 1'b1; bufEntry = entry;
        $display("buffer  pc=%08h tag=%0d instr=%08h", entry.programCounter,
                 entry.programCounterChangedTimes, entry.instruction);
      end
    end else if (!stallOnDecode) begin
      if (bufValid) begin
        expOut = bufEntry; bufValid = 1'b0;
        $display("drain   pc=%08h tag=%0d", bufEntry.programCounter, bufEntry.programCounterChangedTimes);
      end else begin
        expOut.instruction = NOP_INSTRUCTION; expOut.bubbled = 1'b1;
      end
    end
    if (reqFire) begin
      checkValue("reqAddr", {34'b0, imemReqAddr}, {34'b0, expAddr});
      if (!firstSeen) begin firstSeen = 1'b1; firstAddr = imemReqAddr; end
      if (imemReqAddr == 32'h0) sawZero = 1'b1;
      if (nextIsTarget) begin modelTag = ~modelTag; nextIsTarget = 1'b0; end
      entry = '{programCounter: expAddr, programCounterChangedTimes: modelTag,
                instruction: memData(expAddr), bubbled: 1'b0};
      sb.push_back(entry);
      $display("request addr=%08h tag=%0d", expAddr, modelTag);
      if (redirect) begin expAddr = jumpValue; nextIsTarget = 1'b1; pendValid = 1'b0; end
      else if (pendValid) begin expAddr = pendTarget; nextIsTarget = 1'b1; pendValid = 1'b0; end
      else expAddr = expAddr + 32'd4;
    end else if (redirect) begin
      if (imemReqValid) begin pendValid = 1'b1; pendTarget = jumpValue; end
      else begin expAddr = jumpValue; nextIsTarget = 1'b1; pendValid = 1'b0; end
    end
    if (respFire) memBusy = 1'b0;
    if (reqFire) begin
      memBusy = 1'b1; memAddr = imemReqAddr;
      memWait = (latencyMax > 0) ? int'($urandom_range(0, latencyMax)) : 0;
    end else if (memBusy && memWait > 0) begin
      memWait--;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic runUntilFired(input int budget);
    for (int i = 0; i < budget && !armFired; i++) cycle();
    checkValue("redirectApplied", {65'b0, armFired}, {65'b0, 1'b1});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    sawZero = 1'b0;
    modelReset();
    @(posedge clock); #1;
    checkResetState();
    @(negedge clock); reset = 1'b1;

    // sequential fetch, then redirect taken while 0x3008 is being requested
    arm(1'b0, 1'b0, 32'h0000_3008, 32'h0000_3100);
    runUntilFired(40);
    runCycles(8);

    // redirect while the request is held by memory: target waits behind the delay slot
    readyCfg = 1'b0;
    arm(1'b1, 1'b0, 32'h0, 32'h0000_3200);
    runUntilFired(10);
    runCycles(2);
    readyCfg = 1'b1;
    runCycles(8);

    // redirect while a request is in flight
    arm(1'b1, 1'b1, 32'h0, 32'h0000_3300);
    runUntilFired(10);
    runCycles(8);

    // decode stall for 4 cycles with a response pending
    for (int i = 0; i < 20 && !(memBusy && memWait == 0); i++) cycle();
    stallCfg = 1'b1;
    runCycles(4);
    stallCfg = 1'b0;
    runCycles(8);

    // PC wraparound past 0xFFFFFFFC
    arm(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    runUntilFired(10);
    runCycles(8);
    checkValue("wrapToZero", {65'b0, sawZero}, {65'b0, 1'b1});

    // random memory wait states and decode stalls
    latencyMax = 2;
    for (int i = 0; i < 300; i++) begin
      stallCfg = ($urandom_range(0, 3) == 0);
      readyCfg = ($urandom_range(0, 2) != 0);
      cycle();
    end
    stallCfg = 1'b0; readyCfg = 1'b1; latencyMax = 0;
    runCycles(6);

    // asynchronous reset while waiting on memory
    for (int i = 0; i < 20 && !memBusy; i++) cycle();
    checkValue("reachedWait", {65'b0, memBusy}, {65'b0, 1'b1});
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checkResetState();
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    runCycles(8);
    checkValue("firstFetchAfterReset", {34'b0, firstAddr}, {34'b0, RESET_PC});

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
